// File: rtl/lc3_writeback_unit.sv
// LC-3 writeback unit.
//
// Collects results from the ALU and memory paths and drives the single write
// port of the 8x16 register file. Tracks, per register, how many writes are
// still outstanding so that decode can stall on RAW hazards. It also keeps the
// N/Z/P condition codes for the value of each committed write.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   iss_valid/iss_dr/iss_ready  decode reserves a destination register
//   alu_valid/alu_dr/alu_data/alu_ready  ALU result handshake
//   mem_valid/mem_dr/mem_data/mem_ready  memory result handshake (priority)
//   rf_data/rf_dr/rf_ld       register file write port (registered)
//   busy                      busy[r] set while any write to R[r] is pending
//   nzp                       condition codes {N,Z,P}
module lc3_writeback_unit #(
    parameter int unsigned PEND_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [2:0]  iss_dr,
    output logic        iss_ready,
    input  logic        alu_valid,
    input  logic [2:0]  alu_dr,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [2:0]  mem_dr,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    output logic [15:0] rf_data,
    output logic [2:0]  rf_dr,
    output logic        rf_ld,
    output logic [7:0]  busy,
    output logic [2:0]  nzp
);

    localparam logic [PEND_W-1:0] CntMax = '1;
    localparam logic [PEND_W-1:0] CntOne = PEND_W'(1);

    logic [PEND_W-1:0] cnt_q [8];
    logic [PEND_W-1:0] cnt_d [8];
    logic              rf_ld_q;
    logic [2:0]        rf_dr_q;
    logic [15:0]       rf_data_q;
    logic [2:0]        nzp_q, nzp_d;

    logic        accept;
    logic [2:0]  win_dr;
    logic [15:0] win_data;
    logic [7:0]  inc_vec, dec_vec;

    // Memory always wins; the ALU waits while memory presents a result.
    assign mem_ready = 1'b1;
    assign alu_ready = !mem_valid;
    assign iss_ready = (cnt_q[iss_dr] != CntMax);

    always_comb begin
        accept   = 1'b0;
        win_dr   = rf_dr_q;
        win_data = rf_data_q;
        if (mem_valid) begin
            accept   = 1'b1;
            win_dr   = mem_dr;
            win_data = mem_data;
        end else if (alu_valid) begin
            accept   = 1'b1;
            win_dr   = alu_dr;
            win_data = alu_data;
        end
    end

    // Condition codes follow the value being committed this edge.
    always_comb begin
        nzp_d = nzp_q;
        if (rf_ld_q) begin
            if (rf_data_q[15])          nzp_d = 3'b100;
            else if (rf_data_q == '0)   nzp_d = 3'b010;
            else                        nzp_d = 3'b001;
        end
    end

    // Scoreboard: a commit to an unreserved register does not underflow.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy    = '0;
        for (int r = 0; r < 8; r++) begin
            inc_vec[r] = iss_valid && iss_ready && (iss_dr == 3'(r));
            dec_vec[r] = rf_ld_q && (rf_dr_q == 3'(r)) && (cnt_q[r] != '0);
            busy[r]    = (cnt_q[r] != '0);
            cnt_d[r]   = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CntOne;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - CntOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_ld_q   <= 1'b0;
            rf_dr_q   <= '0;
            rf_data_q <= '0;
            nzp_q     <= 3'b010;
            for (int r = 0; r < 8; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            rf_ld_q <= accept;
            if (accept) begin
                rf_dr_q   <= win_dr;
                rf_data_q <= win_data;
            end
            nzp_q <= nzp_d;
            for (int r = 0; r < 8; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign rf_ld   = rf_ld_q;
    assign rf_dr   = rf_dr_q;
    assign rf_data = rf_data_q;
    assign nzp     = nzp_q;

endmodule

// File: tb/tb_lc3_writeback_unit.sv
module tb_lc3_writeback_unit;

    localparam int PEND_W   = 2;
    localparam int MAX_PEND = (1 << PEND_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [2:0]  iss_dr;
    logic        iss_ready;
    logic        alu_valid;
    logic [2:0]  alu_dr;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_dr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [15:0] rf_data;
    logic [2:0]  rf_dr;
    logic        rf_ld;
    logic [7:0]  busy;
    logic [2:0]  nzp;

    int tests = 0;
    int fails = 0;

    // Reference model: outstanding-write counts and the pending commit.
    int          m_cnt [8];
    bit          m_ld;
    int          m_dr;
    logic [15:0] m_data;
    logic [2:0]  m_nzp;

    lc3_writeback_unit #(.PEND_W(PEND_W)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_dr(iss_dr), .iss_ready(iss_ready),
        .alu_valid(alu_valid), .alu_dr(alu_dr), .alu_data(alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .rf_data(rf_data), .rf_dr(rf_dr), .rf_ld(rf_ld),
        .busy(busy), .nzp(nzp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [7:0] busy_exp();
        logic [7:0] b;
        for (int r = 0; r < 8; r++) b[r] = (m_cnt[r] > 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_cnt[r] = 0;
        m_ld   = 1'b0;
        m_dr   = 0;
        m_data = 16'h0000;
        m_nzp  = 3'b010;
    endtask

    task automatic drive(input bit iv, input int idr, input bit av, input int adr,
                         input logic [15:0] ad, input bit mv, input int mdr,
                         input logic [15:0] md);
        iss_valid = iv;  iss_dr = 3'(idr);
        alu_valid = av;  alu_dr = 3'(adr); alu_data = ad;
        mem_valid = mv;  mem_dr = 3'(mdr); mem_data = md;
    endtask

    task automatic check_all();
        chk("iss_ready", 16'(iss_ready), 16'(m_cnt[iss_dr] < MAX_PEND));
        chk("mem_ready", 16'(mem_ready), 16'd1);
        chk("alu_ready", 16'(alu_ready), 16'(!mem_valid));
        chk("busy",      16'(busy),      16'(busy_exp()));
        chk("rf_ld",     16'(rf_ld),     16'(m_ld));
        chk("rf_dr",     16'(rf_dr),     16'(m_dr));
        chk("rf_data",   rf_data,        m_data);
        chk("nzp",       16'(nzp),       16'(m_nzp));
    endtask

    // Check mid-cycle, advance the model by one edge, then step the DUT.
    task automatic cycle();
        bit take_iss;
        @(negedge clk);
        check_all();
        take_iss = iss_valid && (m_cnt[iss_dr] < MAX_PEND);
        if (m_ld) begin
            m_nzp = cc_of(m_data);
            if (m_cnt[m_dr] > 0) m_cnt[m_dr] -= 1;
        end
        if (take_iss) m_cnt[iss_dr] += 1;
        if (mem_valid) begin
            m_ld = 1'b1; m_dr = int'(mem_dr); m_data = mem_data;
        end else if (alu_valid) begin
            m_ld = 1'b1; m_dr = int'(alu_dr); m_data = alu_data;
        end else begin
            m_ld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #12;
        chk("reset_rf_ld", 16'(rf_ld), 16'd0);
        chk("reset_busy",  16'(busy),  16'h00);
        chk("reset_nzp",   16'(nzp),   16'(3'b010));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-stream: cnt[3]=2 and a commit in flight.
        drive(1, 3, 0, 0, 16'h0, 0, 0, 16'h0); cycle();
        drive(1, 3, 0, 0, 16'h0, 1, 1, 16'h1234); cycle();
        idle();
        chk("mid_rf_ld_before", 16'(rf_ld), 16'd1);
        chk("mid_busy_before",  16'(busy),  16'h08);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_rf_ld", 16'(rf_ld), 16'd0);
        chk("mid_rst_busy",  16'(busy),  16'h00);
        chk("mid_rst_nzp",   16'(nzp),   16'(3'b010));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single ALU write to reserved R2.
        drive(1, 2, 0, 0, 16'h0, 0, 0, 16'h0);    cycle();
        drive(0, 0, 1, 2, 16'h8001, 0, 0, 16'h0); cycle();
        idle();
        chk("alu_rf_ld",   16'(rf_ld), 16'd1);
        chk("alu_rf_dr",   16'(rf_dr), 16'd2);
        chk("alu_rf_data", rf_data,    16'h8001);
        cycle();
        chk("alu_busy2", 16'(busy[2]), 16'd0);
        chk("alu_nzp",   16'(nzp),     16'(3'b100));
        chk("alu_ld0",   16'(rf_ld),   16'd0);

        // Collision: memory wins, ALU held and accepted next cycle.
        drive(0, 0, 1, 4, 16'h0005, 1, 1, 16'h0000);
        #1;
        chk("col_mem_ready", 16'(mem_ready), 16'd1);
        chk("col_alu_ready", 16'(alu_ready), 16'd0);
        cycle();
        drive(0, 0, 1, 4, 16'h0005, 0, 0, 16'h0);
        chk("col_first_dr", 16'(rf_dr), 16'd1);
        cycle();
        idle();
        chk("col_nzp_z",     16'(nzp),   16'(3'b010));
        chk("col_second_dr", 16'(rf_dr), 16'd4);
        cycle();
        chk("col_nzp_p", 16'(nzp), 16'(3'b001));

        // Saturation of R6.
        for (int i = 0; i < 3; i++) begin
            drive(1, 6, 0, 0, 16'h0, 0, 0, 16'h0); cycle();
        end
        drive(1, 6, 0, 0, 16'h0, 0, 0, 16'h0);
        #1;
        chk("sat_ready6", 16'(iss_ready), 16'd0);
        chk("sat_busy6",  16'(busy[6]),   16'd1);
        cycle();
        drive(1, 5, 0, 0, 16'h0, 0, 0, 16'h0);
        #1;
        chk("sat_ready5", 16'(iss_ready), 16'd1);
        drive(0, 0, 0, 0, 16'h0, 1, 6, 16'h0042); cycle();
        idle(); cycle();
        drive(1, 6, 0, 0, 16'h0, 0, 0, 16'h0);
        #1;
        chk("sat_ready6_back", 16'(iss_ready), 16'd1);
        cycle();
        idle();

        // Simultaneous issue and commit on R0 with one pending write.
        drive(1, 0, 0, 0, 16'h0, 0, 0, 16'h0);    cycle();
        drive(0, 0, 1, 0, 16'h7777, 0, 0, 16'h0); cycle();
        drive(1, 0, 0, 0, 16'h0, 0, 0, 16'h0);    cycle();
        idle(); cycle();
        chk("same_busy0", 16'(busy[0]), 16'd1);
        drive(0, 0, 1, 0, 16'h0001, 0, 0, 16'h0); cycle();
        idle(); cycle();

        // Unreserved write to R7.
        drive(0, 0, 0, 0, 16'h0, 1, 7, 16'hFFFF); cycle();
        idle();
        chk("unres_rf_ld", 16'(rf_ld), 16'd1);
        cycle();
        chk("unres_busy7", 16'(busy[7]), 16'd0);
        chk("unres_nzp",   16'(nzp),     16'(3'b100));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 45), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 35), int'($urandom_range(0, 7)),
                  (($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom)),
                  ($urandom_range(0, 99) < 25), int'($urandom_range(0, 7)),
                  (($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom)));
            cycle();
        end
        idle();
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
